// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
// Memory-side responder for the system bus. It accepts one block request at
// a time. A read returns one 64-byte line as BEATS data beats, in order
// 0..BEATS-1. A write absorbs BEATS data beats into the local word array and
// has no response phase.
//
// Ports
//   clk          clock
//   reset        synchronous, active-low reset (memory contents survive it)
//   bus_reqcyc   request beat valid (address beat or write data beat)
//   bus_req      byte address on the address beat, data on write data beats
//   bus_reqtag   request tag, sampled on the address beat; MSB=1 means write
//   bus_reqack   request beat accepted (combinational)
//   bus_respcyc  read response beat valid
//   bus_resp     read response data
//   bus_resptag  tag echoed from the accepted read request
//   bus_respack  response beat consumed by the initiator
module sysbus_mem_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 65536,
   parameter int LATENCY        = 4,
   parameter int BEATS          = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack
);

   localparam int AW      = $clog2(MEM_WORDS);
   localparam int BW      = $clog2(BEATS);
   localparam int BASEW   = AW - BW;
   // Byte address bits below the block base: word-in-block plus byte-in-word.
   localparam int BASE_LO = BW + 3;
   localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      RD_WAIT = 2'd2,
      RD_RESP = 2'd3
   } state_t;

   state_t                    state, state_n;
   logic [BW-1:0]             beat, beat_n;
   logic [CW-1:0]             cnt, cnt_n;
   logic [BASEW-1:0]          base_q;
   logic [BUS_TAG_WIDTH-1:0]  tag_q;
   logic                      load;
   logic                      mem_we;
   logic [AW-1:0]             word_idx;

   logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

   // Only the low AW bits of {base,beat} are kept, so addresses past the end
   // of the array wrap silently.
   assign word_idx = {base_q, beat};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         beat  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         beat  <= beat_n;
         cnt   <= cnt_n;
      end
   end

   // Address/tag latch and memory array carry no reset. load and mem_we are
   // derived from bus_reqack, which is already qualified by reset, so a beat
   // offered while reset is low is never absorbed.
   always_ff @(posedge clk) begin
      if (load) begin
         base_q <= bus_req[AW+2:BASE_LO];
         tag_q  <= bus_reqtag;
      end
      if (mem_we) begin
         mem[word_idx] <= bus_req;
      end
   end

   always_comb begin
      state_n     = state;
      beat_n      = beat;
      cnt_n       = cnt;
      load        = 1'b0;
      mem_we      = 1'b0;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      bus_resp    = '0;
      bus_resptag = '0;
      case (state)
         IDLE: begin
            bus_reqack = bus_reqcyc && reset;
            if (bus_reqack) begin
               load = 1'b1;
               if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                  state_n = WR_DATA;
                  beat_n  = '0;
               end else begin
                  state_n = RD_WAIT;
                  cnt_n   = CNT_INIT;
               end
            end
         end
         WR_DATA: begin
            bus_reqack = bus_reqcyc && reset;
            if (bus_reqack) begin
               mem_we = 1'b1;
               beat_n = beat + 1'b1;
               if (beat == LAST_BEAT) begin
                  state_n = IDLE;
               end
            end
         end
         RD_WAIT: begin
            // LATENCY-1 countdown plus the transition edge gives exactly
            // LATENCY edges from accept to the first valid beat.
            if (cnt == '0) begin
               state_n = RD_RESP;
               beat_n  = '0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         RD_RESP: begin
            bus_respcyc = 1'b1;
            bus_resp    = mem[word_idx];
            bus_resptag = tag_q;
            if (bus_respack) begin
               beat_n = beat + 1'b1;
               if (beat == LAST_BEAT) begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder
// Directed bench for sysbus_mem_responder: reset behaviour, write/read of a
// block, response stall, address alignment and wrap, reset in the middle of
// a write burst, and request hold-off while a read is outstanding.
module tb_sysbus_mem_responder;

   localparam int          MEM_WORDS = 65536;
   localparam int          LATENCY   = 4;
   localparam logic [63:0] WRAP_ADDR = 64'(MEM_WORDS) * 64'd8;

   logic        clk;
   logic        reset;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;
   logic        bus_respack;

   int vectors;
   int miscompares;

   logic [63:0] dat_a   [8];
   logic [63:0] dat_b   [8];
   logic [63:0] dat_c   [8];
   logic [63:0] dat_d   [8];
   logic [63:0] dat_mix [8];

   sysbus_mem_responder #(
      .BUS_DATA_WIDTH (64),
      .BUS_TAG_WIDTH  (13),
      .MEM_WORDS      (MEM_WORDS),
      .LATENCY        (LATENCY),
      .BEATS          (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .bus_respack (bus_respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected summary");
      $fatal(1);
   end

   // Advance past the next rising edge; inputs are driven after this.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // Write burst; if stop_at < 8, reset is pulled low when that beat is offered.
   task automatic wr_block(input logic [63:0] addr, input logic [12:0] tag,
                           input logic [63:0] data [8], input int stop_at);
      bus_reqcyc = 1'b1;
      bus_req    = addr;
      bus_reqtag = tag;
      #1 check("wr_addr_ack", 64'(bus_reqack), 64'd1);
      tick();
      for (int i = 0; i < 8; i++) begin
         bus_req = data[i];
         if (i == stop_at) begin
            reset = 1'b0;
            #1 check("wr_reset_ack", 64'(bus_reqack), 64'd0);
            tick();
            reset      = 1'b1;
            bus_reqcyc = 1'b0;
            return;
         end
         #1 check("wr_data_ack", 64'(bus_reqack), 64'd1);
         check("wr_no_resp", 64'(bus_respcyc), 64'd0);
         tick();
      end
      bus_reqcyc = 1'b0;
   endtask

   task automatic rd_addr(input logic [63:0] addr, input logic [12:0] tag);
      bus_reqcyc = 1'b1;
      bus_req    = addr;
      bus_reqtag = tag;
      #1 check("rd_addr_ack", 64'(bus_reqack), 64'd1);
      tick();
      bus_reqcyc = 1'b0;
   endtask

   // Cycles after accept edges E..E+LATENCY-1 must show no response.
   task automatic rd_wait();
      for (int i = 0; i < LATENCY; i++) begin
         #1 check("rd_wait_cyc", 64'(bus_respcyc), 64'd0);
         check("rd_wait_ack", 64'(bus_reqack), 64'd0);
         tick();
      end
   endtask

   task automatic rd_beats(input logic [63:0] exp [8], input logic [12:0] tag,
                           input int stall_beat, input int stall_len);
      bus_respack = 1'b1;
      for (int b = 0; b < 8; b++) begin
         if (b == stall_beat) begin
            bus_respack = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               #1 check("stall_cyc", 64'(bus_respcyc), 64'd1);
               check("stall_data", bus_resp, exp[b]);
               check("stall_tag", 64'(bus_resptag), 64'(tag));
               tick();
            end
            bus_respack = 1'b1;
         end
         #1 check("rd_cyc", 64'(bus_respcyc), 64'd1);
         check("rd_data", bus_resp, exp[b]);
         check("rd_tag", 64'(bus_resptag), 64'(tag));
         check("rd_holdoff", 64'(bus_reqack), 64'd0);
         tick();
      end
      #1 check("rd_done_cyc", 64'(bus_respcyc), 64'd0);
      check("rd_done_data", bus_resp, 64'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 8; i++) begin
         dat_a[i] = 64'hA0 + 64'(i);
         dat_b[i] = 64'h0B0B_0000_0000_00B0 + 64'(i);
         dat_c[i] = 64'hC0C0_0000_0000_00C0 + 64'(i);
         dat_d[i] = 64'hD0D0_0000_0000_00D0 + 64'(i);
         dat_mix[i] = (i < 4) ? dat_d[i] : dat_c[i];
      end

      reset       = 1'b0;
      bus_reqcyc  = 1'b1;
      bus_req     = 64'h1000;
      bus_reqtag  = 13'h1005;
      bus_respack = 1'b0;

      // Reset held with a request pending: nothing is acknowledged.
      for (int i = 0; i < 3; i++) begin
         tick();
         #1 check("rst_reqack", 64'(bus_reqack), 64'd0);
         check("rst_respcyc", 64'(bus_respcyc), 64'd0);
         check("rst_resp", bus_resp, 64'd0);
         check("rst_resptag", 64'(bus_resptag), 64'd0);
      end
      reset      = 1'b1;
      bus_reqcyc = 1'b0;
      tick();

      // Write then read back, respack held high.
      wr_block(64'h1000, 13'h1005, dat_a, 8);
      rd_addr(64'h1000, 13'h0007);
      rd_wait();
      rd_beats(dat_a, 13'h0007, -1, 0);

      // Stall of five cycles on beat 3.
      rd_addr(64'h1000, 13'h0042);
      rd_wait();
      rd_beats(dat_a, 13'h0042, 3, 5);

      // Low six address bits are ignored.
      rd_addr(64'h1038, 13'h0011);
      rd_wait();
      rd_beats(dat_a, 13'h0011, -1, 0);

      // Address MEM_WORDS*8 aliases to block 0.
      wr_block(64'h0, 13'h1001, dat_b, 8);
      rd_addr(WRAP_ADDR, 13'h0022);
      rd_wait();
      rd_beats(dat_b, 13'h0022, -1, 0);

      // Reset at write beat 4: beats 0-3 land, 4-7 keep old contents.
      wr_block(64'h2000, 13'h1010, dat_c, 8);
      wr_block(64'h2000, 13'h1011, dat_d, 4);
      #1 check("mid_rst_cyc", 64'(bus_respcyc), 64'd0);
      tick();
      rd_addr(64'h2000, 13'h0003);
      rd_wait();

      // Hold-off: a new read is offered throughout the current one.
      bus_reqcyc = 1'b1;
      bus_req    = 64'h1000;
      bus_reqtag = 13'h0009;
      rd_beats(dat_mix, 13'h0003, -1, 0);
      check("holdoff_accept", 64'(bus_reqack), 64'd1);
      tick();
      bus_reqcyc = 1'b0;
      rd_wait();
      rd_beats(dat_a, 13'h0009, -1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
